// File: rtl/acx_axi_reg_ctrl_if.sv
// AXI4-Lite channel bundle between the PCIe/NoC target and the register-bus front-end.
// Signal names keep the slave-side i_/o_ view so both ends read the same.
interface acx_axi_reg_ctrl_if #(
    parameter int TGT_ADDR_WIDTH = 28,
    parameter int TGT_DATA_WIDTH = 32
);
    logic [TGT_ADDR_WIDTH-1:0]   i_awaddr;
    logic                        i_awvalid;
    logic                        o_awready;
    logic [TGT_DATA_WIDTH-1:0]   i_wdata;
    logic [TGT_DATA_WIDTH/8-1:0] i_wstrb;
    logic                        i_wvalid;
    logic                        o_wready;
    logic [1:0]                  o_bresp;
    logic                        o_bvalid;
    logic                        i_bready;
    logic [TGT_ADDR_WIDTH-1:0]   i_araddr;
    logic                        i_arvalid;
    logic                        o_arready;
    logic [TGT_DATA_WIDTH-1:0]   o_rdata;
    logic [1:0]                  o_rresp;
    logic                        o_rvalid;
    logic                        i_rready;

    modport slave (
        input  i_awaddr, i_awvalid, i_wdata, i_wstrb, i_wvalid, i_bready,
        input  i_araddr, i_arvalid, i_rready,
        output o_awready, o_wready, o_bresp, o_bvalid,
        output o_arready, o_rdata, o_rresp, o_rvalid
    );

    modport master (
        output i_awaddr, i_awvalid, i_wdata, i_wstrb, i_wvalid, i_bready,
        output i_araddr, i_arvalid, i_rready,
        input  o_awready, o_wready, o_bresp, o_bvalid,
        input  o_arready, o_rdata, o_rresp, o_rvalid
    );
endinterface

// File: rtl/acx_axi_reg_ctrl.sv
// AXI4-Lite slave that sequences one read or write at a time onto the shared register bus,
// waiting for the OR-reduced hit, timing out unmapped accesses and draining late hits.
module acx_axi_reg_ctrl #(
    parameter int                        TGT_ADDR_WIDTH = 28,
    parameter int                        TGT_DATA_WIDTH = 32,
    parameter int                        TIMEOUT        = 16,
    parameter logic [TGT_DATA_WIDTH-1:0] ERR_DATA       = TGT_DATA_WIDTH'(32'hBAD0BAD0)
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    acx_axi_reg_ctrl_if.slave         axi,
    output logic [TGT_ADDR_WIDTH-1:0] o_addr,
    output logic                      o_rd,
    output logic                      o_wr,
    output logic [TGT_DATA_WIDTH-1:0] o_wr_data,
    input  logic                      i_addr_hit,
    input  logic [TGT_DATA_WIDTH-1:0] i_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ACC,
        WR_ACC,
        RD_RESP,
        WR_RESP,
        DRAIN
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);

    state_t     state;
    logic       prio_rd;
    logic       drain_flag;
    logic       strb_ok;
    logic [7:0] tmo_cnt;
    logic [1:0] drain_cnt;

    logic write_req;
    logic read_req;
    logic grant_rd;
    logic grant_wr;

    // On contention the type not served last wins; prio_rd points at the preferred type.
    assign write_req = axi.i_awvalid & axi.i_wvalid;
    assign read_req  = axi.i_arvalid;
    assign grant_rd  = read_req & (~write_req | prio_rd);
    assign grant_wr  = write_req & (~read_req | ~prio_rd);

    // The first ACC cycle is the grant cycle (ready high, strobe still low); the strobe follows.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state         <= IDLE;
            prio_rd       <= 1'b1;
            drain_flag    <= 1'b0;
            strb_ok       <= 1'b0;
            tmo_cnt       <= '0;
            drain_cnt     <= '0;
            o_addr        <= '0;
            o_rd          <= 1'b0;
            o_wr          <= 1'b0;
            o_wr_data     <= '0;
            axi.o_arready <= 1'b0;
            axi.o_awready <= 1'b0;
            axi.o_wready  <= 1'b0;
            axi.o_rvalid  <= 1'b0;
            axi.o_rdata   <= '0;
            axi.o_rresp   <= RESP_OKAY;
            axi.o_bvalid  <= 1'b0;
            axi.o_bresp   <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt    <= '0;
                    drain_flag <= 1'b0;
                    if (grant_rd) begin
                        axi.o_arready <= 1'b1;
                        o_addr        <= axi.i_araddr;
                        prio_rd       <= 1'b0;
                        state         <= RD_ACC;
                    end else if (grant_wr) begin
                        axi.o_awready <= 1'b1;
                        axi.o_wready  <= 1'b1;
                        o_addr        <= axi.i_awaddr;
                        o_wr_data     <= axi.i_wdata;
                        strb_ok       <= &axi.i_wstrb;
                        prio_rd       <= 1'b1;
                        state         <= WR_ACC;
                    end
                end

                RD_ACC: begin
                    if (axi.o_arready) begin
                        axi.o_arready <= 1'b0;
                        o_rd          <= 1'b1;
                    end else if (i_addr_hit) begin
                        o_rd         <= 1'b0;
                        axi.o_rdata  <= i_read_data;
                        axi.o_rresp  <= RESP_OKAY;
                        axi.o_rvalid <= 1'b1;
                        state        <= RD_RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        o_rd         <= 1'b0;
                        axi.o_rdata  <= ERR_DATA;
                        axi.o_rresp  <= RESP_SLVERR;
                        axi.o_rvalid <= 1'b1;
                        drain_flag   <= 1'b1;
                        state        <= RD_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                // A partial strobe is refused outright, so the bus never sees a half write.
                WR_ACC: begin
                    if (axi.o_awready) begin
                        axi.o_awready <= 1'b0;
                        axi.o_wready  <= 1'b0;
                        if (strb_ok) begin
                            o_wr <= 1'b1;
                        end else begin
                            axi.o_bresp  <= RESP_SLVERR;
                            axi.o_bvalid <= 1'b1;
                            state        <= WR_RESP;
                        end
                    end else if (i_addr_hit) begin
                        o_wr         <= 1'b0;
                        axi.o_bresp  <= RESP_OKAY;
                        axi.o_bvalid <= 1'b1;
                        state        <= WR_RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        o_wr         <= 1'b0;
                        axi.o_bresp  <= RESP_SLVERR;
                        axi.o_bvalid <= 1'b1;
                        drain_flag   <= 1'b1;
                        state        <= WR_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                RD_RESP: begin
                    drain_cnt <= '0;
                    if (axi.i_rready) begin
                        axi.o_rvalid <= 1'b0;
                        state        <= drain_flag ? DRAIN : IDLE;
                    end
                end

                WR_RESP: begin
                    drain_cnt <= '0;
                    if (axi.i_bready) begin
                        axi.o_bvalid <= 1'b0;
                        state        <= drain_flag ? DRAIN : IDLE;
                    end
                end

                // Late hits from a slow or misdecoded register are absorbed here.
                DRAIN: begin
                    drain_cnt <= drain_cnt + 2'd1;
                    if (drain_cnt == 2'd2) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acx_axi_reg_ctrl.sv
// Scoreboard bench for acx_axi_reg_ctrl: a small register-bank model answers on the register bus
// and expected AXI responses are queued at stimulus time and compared at each handshake.
module tb_acx_axi_reg_ctrl;

    localparam int AW = 28;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    acx_axi_reg_ctrl_if #(.TGT_ADDR_WIDTH(AW), .TGT_DATA_WIDTH(DW)) axi ();

    logic [AW-1:0] regAddr;
    logic          regRd;
    logic          regWr;
    logic [DW-1:0] regWrData;
    logic          addrHit;
    logic [DW-1:0] readData;

    acx_axi_reg_ctrl #(
        .TGT_ADDR_WIDTH(AW),
        .TGT_DATA_WIDTH(DW),
        .TIMEOUT(16),
        .ERR_DATA(32'hBAD0BAD0)
    ) dut (
        .i_clk(clk),
        .i_rstn(rstn),
        .axi(axi),
        .o_addr(regAddr),
        .o_rd(regRd),
        .o_wr(regWr),
        .o_wr_data(regWrData),
        .i_addr_hit(addrHit),
        .i_read_data(readData)
    );

    // Register bank model: addresses below 0x100 are mapped and hit two cycles after the strobe rises.
    logic [31:0] regFile [0:63];
    int          strobeAge = 0;
    logic        injectHit = 1'b0;
    logic [31:0] injectData = 32'h0;
    logic        mapped;
    logic        modelHit;

    always @(posedge clk) strobeAge <= (regRd || regWr) ? strobeAge + 1 : 0;
    assign mapped   = (regAddr < 28'h100);
    assign modelHit = (regRd || regWr) && (strobeAge == 2) && mapped;
    assign addrHit  = modelHit || injectHit;
    assign readData = ((modelHit && regRd) ? regFile[regAddr[7:2]] : 32'h0) | (injectHit ? injectData : 32'h0);

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rdExp_t;

    rdExp_t     rdQ[$];
    logic [1:0] bQ[$];
    bit         grantLog[$];
    rdExp_t     eR;
    logic [1:0] eB;

    int cycle = 0;
    int arCycle = -1, awCycle = -1, rdRise = -1, wrRise = -1, rvCycle = -1, bvCycle = -1;
    int rdHigh = 0, wrHigh = 0, awHigh = 0, wHigh = 0;
    logic [31:0] wrDataSeen = 32'h0;
    logic prevRd = 1'b0, prevWr = 1'b0, prevRv = 1'b0, prevBv = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: event timestamps, strobe lengths, grant order and scoreboard pops.
    always @(negedge clk) begin
        if (axi.o_arready) begin
            arCycle = cycle;
            grantLog.push_back(1'b1);
        end
        if (axi.o_awready) begin
            awCycle = cycle;
            awHigh++;
            grantLog.push_back(1'b0);
        end
        if (axi.o_wready) wHigh++;
        if (regRd) rdHigh++;
        if (regRd && !prevRd) rdRise = cycle;
        prevRd = regRd;
        if (regWr) begin
            wrHigh++;
            wrDataSeen = regWrData;
        end
        if (regWr && !prevWr) wrRise = cycle;
        prevWr = regWr;
        if (axi.o_rvalid && !prevRv) rvCycle = cycle;
        prevRv = axi.o_rvalid;
        if (axi.o_bvalid && !prevBv) bvCycle = cycle;
        prevBv = axi.o_bvalid;

        if (axi.o_rvalid && axi.i_rready) begin
            if (rdQ.size() == 0) begin
                checkOutput("rd_unexpected", 32'd1, 32'd0);
            end else begin
                eR = rdQ.pop_front();
                checkOutput("rdata", axi.o_rdata, eR.data);
                checkOutput("rresp", 32'(axi.o_rresp), 32'(eR.resp));
            end
        end
        if (axi.o_bvalid && axi.i_bready) begin
            if (bQ.size() == 0) begin
                checkOutput("b_unexpected", 32'd1, 32'd0);
            end else begin
                eB = bQ.pop_front();
                checkOutput("bresp", 32'(axi.o_bresp), 32'(eB));
            end
        end
    end

    task automatic checkReset(input string tag);
        checkOutput({tag, "_arready"}, 32'(axi.o_arready), 32'd0);
        checkOutput({tag, "_awready"}, 32'(axi.o_awready), 32'd0);
        checkOutput({tag, "_wready"},  32'(axi.o_wready),  32'd0);
        checkOutput({tag, "_rvalid"},  32'(axi.o_rvalid),  32'd0);
        checkOutput({tag, "_bvalid"},  32'(axi.o_bvalid),  32'd0);
        checkOutput({tag, "_rd"},      32'(regRd),         32'd0);
        checkOutput({tag, "_wr"},      32'(regWr),         32'd0);
        checkOutput({tag, "_addr"},    32'(regAddr),       32'd0);
        checkOutput({tag, "_wrdata"},  regWrData,          32'd0);
        checkOutput({tag, "_rdata"},   axi.o_rdata,        32'd0);
        checkOutput({tag, "_rresp"},   32'(axi.o_rresp),   32'd0);
        checkOutput({tag, "_bresp"},   32'(axi.o_bresp),   32'd0);
    endtask

    // Drive one request and hold it until the DUT grants it.
    task automatic applyStimulus(input bit isRead, input logic [AW-1:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb);
        bit granted = 1'b0;
        if (isRead) begin
            axi.i_araddr  = addr;
            axi.i_arvalid = 1'b1;
        end else begin
            axi.i_awaddr  = addr;
            axi.i_wdata   = data;
            axi.i_wstrb   = strb;
            axi.i_awvalid = 1'b1;
            axi.i_wvalid  = 1'b1;
        end
        for (int i = 0; i < 50 && !granted; i++) begin
            @(negedge clk);
            granted = isRead ? axi.o_arready : axi.o_awready;
        end
        if (!granted) checkOutput("grant_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        axi.i_arvalid = 1'b0;
        axi.i_awvalid = 1'b0;
        axi.i_wvalid  = 1'b0;
    endtask

    task automatic waitResp(input bit isRead);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = isRead ? (axi.o_rvalid && axi.i_rready) : (axi.o_bvalid && axi.i_bready);
        end
        if (!done) checkOutput("resp_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int drain0;
        bit done;
        for (int i = 0; i < 64; i++) regFile[i] = 32'h0;
        regFile[4] = 32'hDEADBEEF;
        axi.i_awaddr  = '0;
        axi.i_awvalid = 1'b0;
        axi.i_wdata   = '0;
        axi.i_wstrb   = '0;
        axi.i_wvalid  = 1'b0;
        axi.i_bready  = 1'b1;
        axi.i_araddr  = '0;
        axi.i_arvalid = 1'b0;
        axi.i_rready  = 1'b1;

        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkReset("por");
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] mapped read");
        rdHigh = 0;
        rdQ.push_back('{32'hDEADBEEF, 2'b00});
        applyStimulus(1'b1, 28'h0000010, 32'h0, 4'h0);
        waitResp(1'b1);
        checkOutput("rd_rise",    32'(rdRise),  32'(arCycle + 1));
        checkOutput("rd_len",     32'(rdHigh),  32'd3);
        checkOutput("rvalid_lat", 32'(rvCycle), 32'(arCycle + 4));

        $display("[TB] mapped write");
        wrHigh = 0; awHigh = 0; wHigh = 0;
        bQ.push_back(2'b00);
        applyStimulus(1'b0, 28'h0000020, 32'h12345678, 4'hF);
        waitResp(1'b0);
        checkOutput("aw_pulse",   32'(awHigh),  32'd1);
        checkOutput("w_pulse",    32'(wHigh),   32'd1);
        checkOutput("wr_rise",    32'(wrRise),  32'(awCycle + 1));
        checkOutput("wr_len",     32'(wrHigh),  32'd3);
        checkOutput("wr_data",    wrDataSeen,   32'h12345678);
        checkOutput("bvalid_lat", 32'(bvCycle), 32'(wrRise + 3));

        $display("[TB] unmapped read, timeout and drain");
        rdHigh = 0;
        rdQ.push_back('{32'hBAD0BAD0, 2'b10});
        applyStimulus(1'b1, 28'h0000400, 32'h0, 4'h0);
        waitResp(1'b1);
        checkOutput("tmo_rd_len",  32'(rdHigh),  32'd16);
        checkOutput("tmo_rvalid",  32'(rvCycle), 32'(arCycle + 17));
        drain0 = cycle;
        rdHigh = 0;
        injectData = 32'h0F0F0F0F;
        rdQ.push_back('{32'hDEADBEEF, 2'b00});
        fork
            begin
                injectHit = 1'b1;
                repeat (2) @(posedge clk);
                #1 injectHit = 1'b0;
            end
            applyStimulus(1'b1, 28'h0000010, 32'h0, 4'h0);
        join
        checkOutput("drain_grant", 32'(arCycle), 32'(drain0 + 4));
        waitResp(1'b1);
        checkOutput("post_drain_rd_len", 32'(rdHigh), 32'd3);

        $display("[TB] reset then contended grants");
        rstn = 1'b0;
        @(negedge clk);
        checkReset("rst2");
        @(posedge clk);
        #1 rstn = 1'b1;
        grantLog.delete();
        rdQ.push_back('{32'hDEADBEEF, 2'b00});
        rdQ.push_back('{32'hDEADBEEF, 2'b00});
        bQ.push_back(2'b00);
        bQ.push_back(2'b00);
        axi.i_araddr  = 28'h0000010;
        axi.i_awaddr  = 28'h0000024;
        axi.i_wdata   = 32'hA5A50001;
        axi.i_wstrb   = 4'hF;
        axi.i_arvalid = 1'b1;
        axi.i_awvalid = 1'b1;
        axi.i_wvalid  = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = (grantLog.size() >= 4);
        end
        @(posedge clk);
        #1;
        axi.i_arvalid = 1'b0;
        axi.i_awvalid = 1'b0;
        axi.i_wvalid  = 1'b0;
        checkOutput("alt_count", 32'(grantLog.size()), 32'd4);
        if (grantLog.size() >= 4) begin
            for (int k = 0; k < 4; k++)
                checkOutput($sformatf("alt_grant%0d", k), 32'(grantLog[k]), 32'((k % 2) == 0));
        end
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = (rdQ.size() == 0) && (bQ.size() == 0);
        end
        checkOutput("alt_drained", 32'(done), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] partial strobe write");
        wrHigh = 0;
        bQ.push_back(2'b10);
        applyStimulus(1'b0, 28'h0000028, 32'hCAFE0000, 4'h3);
        waitResp(1'b0);
        checkOutput("pstrb_wr_len", 32'(wrHigh),  32'd0);
        checkOutput("pstrb_bvalid", 32'(bvCycle), 32'(awCycle + 1));

        $display("[TB] backpressure then mid-response reset");
        axi.i_rready = 1'b0;
        applyStimulus(1'b1, 28'h0000010, 32'h0, 4'h0);
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = axi.o_rvalid;
        end
        checkOutput("bp_rvalid_seen", 32'(done), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_rvalid%0d", k), 32'(axi.o_rvalid), 32'd1);
            checkOutput($sformatf("bp_rdata%0d", k),  axi.o_rdata,       32'hDEADBEEF);
        end
        #2 rstn = 1'b0;
        #1 checkReset("midrst");
        @(posedge clk);
        #1;
        axi.i_rready = 1'b1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        checkOutput("sb_empty", 32'(rdQ.size() + bQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
